// File: rtl/bsg_cgol_test_node_master.sv
// Master end of the CGoL test-node ring link: replays a stimulus stream to the client as
// ring packets, then checks the returned result packets against an expected-word stream.
module bsg_cgol_test_node_master #(
  parameter int ring_width_p   = 80,
  parameter int client_id_p    = 0,
  parameter int num_tx_words_p = 101,
  parameter int num_rx_words_p = 100,
  parameter int timeout_p      = 4096
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  output logic                    en_o,
  input  logic                    tr_v_i,
  input  logic [63:0]             tr_data_i,
  output logic                    tr_yumi_o,
  input  logic                    exp_v_i,
  input  logic [63:0]             exp_data_i,
  output logic                    exp_yumi_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    ready_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    yumi_o,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic                    bad_id_o,
  output logic [15:0]             err_count_o
);

  localparam logic [1:0] state_idle = 2'd0;
  localparam logic [1:0] state_send = 2'd1;
  localparam logic [1:0] state_recv = 2'd2;
  localparam logic [1:0] state_done = 2'd3;

  localparam int tx_cnt_w = $clog2(num_tx_words_p + 1);
  localparam int rx_cnt_w = $clog2(num_rx_words_p + 1);
  localparam int to_cnt_w = (timeout_p > 2) ? $clog2(timeout_p) : 1;

  localparam logic [tx_cnt_w-1:0] tx_total   = tx_cnt_w'(num_tx_words_p);
  localparam logic [tx_cnt_w-1:0] tx_last_ix = tx_cnt_w'(num_tx_words_p - 1);
  localparam logic [rx_cnt_w-1:0] rx_last_ix = rx_cnt_w'(num_rx_words_p - 1);
  localparam logic [to_cnt_w-1:0] to_last    = to_cnt_w'(timeout_p - 1);
  localparam logic [3:0]          client_id  = 4'(client_id_p);

  logic [1:0]              state_r;
  logic                    tx_v_r;
  logic [ring_width_p-1:0] tx_data_r;
  logic [tx_cnt_w-1:0]     load_cnt_r;
  logic [tx_cnt_w-1:0]     xfer_cnt_r;
  logic [rx_cnt_w-1:0]     rx_cnt_r;
  logic [to_cnt_w-1:0]     to_cnt_r;
  logic                    timeout_r;
  logic                    bad_id_r;
  logic [15:0]             err_cnt_r;

  logic                    in_send, in_recv;
  logic                    tx_xfer, tx_load, tx_last;
  logic                    rx_yumi, id_ok, rx_ok, rx_last, mismatch, to_hit;
  logic [ring_width_p-1:0] tx_pkt;

  always_comb begin
    tx_pkt        = '0;
    tx_pkt[63:0]  = tr_data_i;
    tx_pkt[78:75] = client_id;
  end

  assign in_send = (state_r == state_send);
  assign in_recv = (state_r == state_recv);

  // The buffer may refill in the same cycle its word is taken, giving one word per cycle.
  assign tx_xfer = tx_v_r & ready_i;
  assign tx_load = in_send & tr_v_i & (load_cnt_r != tx_total) & (~tx_v_r | ready_i);
  assign tx_last = tx_xfer & (xfer_cnt_r == tx_last_ix);

  assign id_ok    = (data_i[78:75] == client_id);
  assign rx_yumi  = in_recv & v_i & exp_v_i;
  assign rx_ok    = rx_yumi & id_ok;
  assign mismatch = rx_ok & (data_i[63:0] != exp_data_i);
  assign rx_last  = rx_ok & (rx_cnt_r == rx_last_ix);
  assign to_hit   = in_recv & ~rx_yumi & (to_cnt_r == to_last);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r    <= state_idle;
      tx_v_r     <= 1'b0;
      tx_data_r  <= '0;
      load_cnt_r <= '0;
      xfer_cnt_r <= '0;
      rx_cnt_r   <= '0;
      to_cnt_r   <= '0;
      timeout_r  <= 1'b0;
      bad_id_r   <= 1'b0;
      err_cnt_r  <= '0;
    end else begin
      case (state_r)
        state_idle, state_done: begin
          if (start_i) begin
            state_r    <= state_send;
            tx_v_r     <= 1'b0;
            load_cnt_r <= '0;
            xfer_cnt_r <= '0;
            rx_cnt_r   <= '0;
            to_cnt_r   <= '0;
            timeout_r  <= 1'b0;
            bad_id_r   <= 1'b0;
            err_cnt_r  <= '0;
          end
        end
        state_send: begin
          if (tx_load) begin
            tx_v_r     <= 1'b1;
            tx_data_r  <= tx_pkt;
            load_cnt_r <= load_cnt_r + 1'b1;
          end else if (tx_xfer) begin
            tx_v_r <= 1'b0;
          end
          if (tx_xfer) xfer_cnt_r <= xfer_cnt_r + 1'b1;
          if (tx_last) begin
            state_r  <= state_recv;
            tx_v_r   <= 1'b0;
            to_cnt_r <= '0;
          end
        end
        default: begin
          // An accepted last word takes priority over an expiring timeout in the same cycle.
          if (rx_yumi) begin
            to_cnt_r <= '0;
            if (!id_ok) begin
              bad_id_r <= 1'b1;
            end else begin
              rx_cnt_r <= rx_cnt_r + 1'b1;
              if (mismatch && (err_cnt_r != 16'hFFFF)) err_cnt_r <= err_cnt_r + 1'b1;
            end
            if (rx_last) state_r <= state_done;
          end else if (to_hit) begin
            timeout_r <= 1'b1;
            state_r   <= state_done;
          end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
          end
        end
      endcase
    end
  end

  assign en_o        = in_send | in_recv;
  assign tr_yumi_o   = tx_load;
  assign v_o         = tx_v_r;
  assign data_o      = tx_data_r;
  assign yumi_o      = rx_yumi;
  assign exp_yumi_o  = rx_ok;
  assign done_o      = (state_r == state_done);
  assign timeout_o   = timeout_r;
  assign bad_id_o    = bad_id_r;
  assign err_count_o = err_cnt_r;

endmodule

// File: tb/tb_bsg_cgol_test_node_master.sv
// Directed bench for bsg_cgol_test_node_master: tx replay, backpressure, rx checking,
// bad id, timeout and mid-game reset.
module tb_bsg_cgol_test_node_master;

  logic        clk_i = 1'b0;
  logic        reset_i, start_i, en_o;
  logic        tr_v_i, tr_yumi_o, exp_v_i, exp_yumi_o;
  logic [63:0] tr_data_i, exp_data_i;
  logic        v_o, ready_i, v_i, yumi_o, done_o, timeout_o, bad_id_o;
  logic [79:0] data_o, data_i;
  logic [15:0] err_count_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bsg_cgol_test_node_master #(
    .ring_width_p  (80),
    .client_id_p   (0),
    .num_tx_words_p(101),
    .num_rx_words_p(100),
    .timeout_p     (16)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .en_o       (en_o),
    .tr_v_i     (tr_v_i),
    .tr_data_i  (tr_data_i),
    .tr_yumi_o  (tr_yumi_o),
    .exp_v_i    (exp_v_i),
    .exp_data_i (exp_data_i),
    .exp_yumi_o (exp_yumi_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .ready_i    (ready_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .yumi_o     (yumi_o),
    .done_o     (done_o),
    .timeout_o  (timeout_o),
    .bad_id_o   (bad_id_o),
    .err_count_o(err_count_o)
  );

  function automatic logic [63:0] expw(input int k);
    return 64'h1234_5678_0000_0000 ^ 64'(k);
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start();
    v_i = 1'b0; exp_v_i = 1'b0; tr_v_i = 1'b0; ready_i = 1'b0;
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    #1;
    checks++;
    if ({en_o, done_o, timeout_o, bad_id_o, err_count_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL start_state actual en/done/to/bad/err=%b%b%b%b %h required 1000 0000",
               en_o, done_o, timeout_o, bad_id_o, err_count_o);
    end
    #1;
  endtask

  // mode 0: ready always high; mode 1: ready high one cycle in three
  task automatic run_send(input int mode, input logic [63:0] base);
    int tr_idx = 0, xfer = 0, cyc = 0;
    logic started = 1'b0;
    logic [79:0] exp_pkt;
    while (xfer < 101 && cyc < 2000) begin
      ready_i   = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      tr_v_i    = 1'b1;
      tr_data_i = base + 64'(tr_idx);
      #1;
      exp_pkt = {1'b0, 4'h0, 11'h0, base + 64'(xfer)};
      if (mode == 0 && started) begin
        checks++;
        if (v_o !== 1'b1) begin
          failures++;
          $display("FAIL send_gap actual v_o=%b required 1 at transfer %0d", v_o, xfer);
        end
      end
      if (v_o === 1'b1) begin
        checks++;
        if (data_o !== exp_pkt) begin
          failures++;
          $display("FAIL send_data actual=%h required=%h", data_o, exp_pkt);
        end
        if (ready_i) begin
          xfer++;
          started = 1'b1;
        end
      end
      if (tr_yumi_o === 1'b1) tr_idx++;
      next_cycle();
      cyc++;
    end
    checks++;
    if (xfer != 101 || tr_idx != 101) begin
      failures++;
      $display("FAIL send_count actual xfer=%0d loads=%0d required 101 101", xfer, tr_idx);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != 102) begin
        failures++;
        $display("FAIL send_b2b_cycles actual=%0d required=102", cyc);
      end
    end
    ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({tr_yumi_o, v_o, en_o, done_o} !== 4'b0010) begin
        failures++;
        $display("FAIL recv_entry actual yumi/v/en/done=%b%b%b%b required 0010",
                 tr_yumi_o, v_o, en_o, done_o);
      end
      next_cycle();
    end
    tr_v_i = 1'b0;
  endtask

  task automatic run_recv(input int n, input int c_a, input int c_b, input int bad_at);
    int rx = 0, cyc = 0;
    logic bad_done = 1'b0, gap_done = 1'b0, is_bad, is_gap;
    while (rx < n && cyc < 500) begin
      is_bad = (rx == bad_at) && !bad_done;
      is_gap = (rx == 7) && !gap_done;
      exp_v_i    = !is_gap;
      exp_data_i = expw(rx);
      v_i        = 1'b1;
      if (is_bad) data_i = {1'b0, 4'h3, 11'h0, 64'hDEAD_BEEF_0000_0000};
      else data_i = {1'b0, 4'h0, 11'h5A5, expw(rx) ^ 64'((rx == c_a || rx == c_b) ? 1 : 0)};
      #1;
      checks++;
      if ({yumi_o, exp_yumi_o} !== {!is_gap, !(is_gap || is_bad)}) begin
        failures++;
        $display("FAIL recv_handshake actual yumi/exp_yumi=%b%b required %b%b at word %0d",
                 yumi_o, exp_yumi_o, !is_gap, !(is_gap || is_bad), rx);
      end
      if (is_gap) gap_done = 1'b1;
      else if (is_bad) bad_done = 1'b1;
      else rx++;
      next_cycle();
      cyc++;
    end
    v_i = 1'b0;
    exp_v_i = 1'b0;
  endtask

  task automatic check_done(input logic [15:0] e_err, input logic e_bad, input logic e_to);
    v_i = 1'b1; exp_v_i = 1'b1;
    #1;
    checks++;
    if ({done_o, en_o, v_o, yumi_o, exp_yumi_o} !== 5'b10000) begin
      failures++;
      $display("FAIL done_state actual done/en/v/yumi/exp_yumi=%b%b%b%b%b required 10000",
               done_o, en_o, v_o, yumi_o, exp_yumi_o);
    end
    checks++;
    if ({err_count_o, bad_id_o, timeout_o} !== {e_err, e_bad, e_to}) begin
      failures++;
      $display("FAIL done_status actual err=%h bad=%b to=%b required err=%h bad=%b to=%b",
               err_count_o, bad_id_o, timeout_o, e_err, e_bad, e_to);
    end
    v_i = 1'b0; exp_v_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; start_i = 1'b0; tr_v_i = 1'b0; tr_data_i = '0; exp_v_i = 1'b0;
    exp_data_i = '0; ready_i = 1'b0; v_i = 1'b0; data_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({en_o, tr_yumi_o, exp_yumi_o, v_o, data_o, yumi_o, done_o, timeout_o, bad_id_o, err_count_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs actual nonzero en=%b v=%b data=%h done=%b err=%h required all 0",
               en_o, v_o, data_o, done_o, err_count_o);
    end
    reset_i = 1'b1;
    next_cycle();
  endtask

  task automatic test_send_back_to_back();
    do_start();
    run_send(0, 64'h0);
  endtask

  task automatic test_loopback();
    run_recv(100, -1, -1, -1);
    check_done(16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure_corrupt();
    do_start();
    run_send(1, 64'hC0DE_0000_0000_0100);
    run_recv(100, 5, 99, -1);
    check_done(16'd2, 1'b0, 1'b0);
  endtask

  task automatic test_bad_id();
    do_start();
    run_send(0, 64'h0BAD_0000_0000_0000);
    run_recv(100, -1, -1, 50);
    check_done(16'd0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int c = 0;
    do_start();
    run_send(0, 64'h7700_0000_0000_0000);
    run_recv(10, -1, -1, -1);
    exp_v_i = 1'b1;
    while (c < 40) begin
      next_cycle();
      c++;
      if (done_o === 1'b1) break;
    end
    exp_v_i = 1'b0;
    checks++;
    if (c != 16) begin
      failures++;
      $display("FAIL timeout_latency actual=%0d required=16 cycles", c);
    end
    check_done(16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_send();
    do_start();
    tr_v_i = 1'b1; tr_data_i = 64'hFFFF_FFFF_FFFF_FFFF; ready_i = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if (v_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_send_pending actual v_o=%b required 1", v_o);
    end
    reset_i = 1'b0;
    #1;
    checks++;
    if ({en_o, tr_yumi_o, exp_yumi_o, v_o, data_o, yumi_o, done_o, timeout_o, bad_id_o, err_count_o} !== '0) begin
      failures++;
      $display("FAIL async_reset actual en=%b tr_yumi=%b v=%b data=%h required all 0",
               en_o, tr_yumi_o, v_o, data_o);
    end
    next_cycle();
    reset_i = 1'b1;
    ready_i = 1'b1;
    next_cycle();
    checks++;
    if ({en_o, tr_yumi_o, v_o, done_o} !== 4'b0000) begin
      failures++;
      $display("FAIL idle_after_reset actual en/tr_yumi/v/done=%b%b%b%b required 0000",
               en_o, tr_yumi_o, v_o, done_o);
    end
    tr_v_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_send_back_to_back();
    test_loopback();
    test_backpressure_corrupt();
    test_bad_id();
    test_timeout();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
